// File: rtl/bubble_pkg.sv
// bubble_pkg: shared ball-stage type and default widths for the ball sequencing blocks
package bubble_pkg;
  typedef enum logic [1:0] {S_HUGE, S_BIG, S_CLEARED} ball_stage_t;
  localparam int X_W = 11;
  localparam int INVULN_FRAMES = 60;
endpackage

// File: rtl/hugeball_split_controller_if.sv
// hugeball_split_controller_if: frame/collision inputs and ball-control outputs of the split controller
// master drives frame control, collision strobes and hugeBallX; slave (the controller) drives enables, pulses and status
interface hugeball_split_controller_if #(parameter int X_W = bubble_pkg::X_W);
  logic startOfFrame;
  logic startLevel;
  logic col_player_hugeBall;
  logic col_rope_hugeBall;
  logic col_player_bigBall1;
  logic col_rope_bigBall1;
  logic col_player_bigBall2;
  logic col_rope_bigBall2;
  logic [X_W-1:0] hugeBallX;
  logic [X_W-1:0] spawnX;
  logic hugeBall_en;
  logic bigBall1_en;
  logic bigBall2_en;
  logic bigBall_spawn;
  logic rope_reset;
  logic player_hit;
  logic player_invuln;
  logic level_cleared;
  modport master (
    output startOfFrame, startLevel, hugeBallX,
    output col_player_hugeBall, col_rope_hugeBall, col_player_bigBall1, col_rope_bigBall1, col_player_bigBall2, col_rope_bigBall2,
    input spawnX, hugeBall_en, bigBall1_en, bigBall2_en, bigBall_spawn, rope_reset, player_hit, player_invuln, level_cleared
  );
  modport slave (
    input startOfFrame, startLevel, hugeBallX,
    input col_player_hugeBall, col_rope_hugeBall, col_player_bigBall1, col_rope_bigBall1, col_player_bigBall2, col_rope_bigBall2,
    output spawnX, hugeBall_en, bigBall1_en, bigBall2_en, bigBall_spawn, rope_reset, player_hit, player_invuln, level_cleared
  );
endinterface

// File: rtl/collision_frame_latch.sv
// collision_frame_latch: N sticky collision flags, reloaded from the live strobes on startOfFrame
// ports: clk, resetN (sync, active-low), clr (sync clear), startOfFrame, colIn[N] strobes, flags[N] = this frame's accumulated hits
module collision_frame_latch #(parameter int N = 6) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         clr,
  input  logic         startOfFrame,
  input  logic [N-1:0] colIn,
  output logic [N-1:0] flags
);
  // flags always hold the pre-edge snapshot; a strobe on the frame edge seeds the next frame
  always_ff @(posedge clk)
    if (!resetN || clr) flags <= '0;
    else flags <= startOfFrame ? colIn : flags | colIn;
endmodule

// File: rtl/hugeball_split_controller.sv
// hugeball_split_controller: per-frame huge-ball split, big-ball retire, player-hit and level-clear sequencer
// ports: clk, resetN (sync, active-low), bus (slave): startOfFrame/startLevel, six collision strobes, hugeBallX in;
//        ball enables, spawnX, bigBall_spawn/rope_reset/player_hit pulses, player_invuln, level_cleared out
module hugeball_split_controller #(
  parameter int INVULN_FRAMES = bubble_pkg::INVULN_FRAMES,
  parameter int CNT_W = 6,
  parameter int X_W = bubble_pkg::X_W
) (
  input logic clk,
  input logic resetN,
  hugeball_split_controller_if.slave bus
);
  import bubble_pkg::*;
  ball_stage_t stage;
  logic [5:0] flags;
  logic [CNT_W-1:0] cnt;
  logic [X_W-1:0] spawnX;
  logic hugeEn, big1, big2, spawn, ropeRst, hit, cleared;
  logic ret1, ret2, playerHit;
  collision_frame_latch #(.N(6)) u_latch (
    .clk(clk),
    .resetN(resetN),
    .clr(bus.startLevel),
    .startOfFrame(bus.startOfFrame),
    .colIn({bus.col_rope_bigBall2, bus.col_player_bigBall2, bus.col_rope_bigBall1,
            bus.col_player_bigBall1, bus.col_rope_hugeBall, bus.col_player_hugeBall}),
    .flags(flags)
  );
  // only hits on balls that are alive at evaluation time count
  assign ret1 = flags[3] & big1;
  assign ret2 = flags[5] & big2;
  assign playerHit = (stage != S_CLEARED) & ((flags[0] & hugeEn) | (flags[2] & big1) | (flags[4] & big2));
  always_ff @(posedge clk) begin
    if (!resetN || bus.startLevel) begin
      stage <= S_HUGE;
      hugeEn <= 1'b1;
      big1 <= 1'b0;
      big2 <= 1'b0;
      spawn <= 1'b0;
      ropeRst <= 1'b0;
      hit <= 1'b0;
      cleared <= 1'b0;
      cnt <= '0;
      if (!resetN) spawnX <= '0;
    end else begin
      spawn <= 1'b0;
      ropeRst <= 1'b0;
      hit <= 1'b0;
      // first rope contact of the frame fixes where the big balls appear
      if (bus.col_rope_hugeBall && !flags[1]) spawnX <= bus.hugeBallX;
      if (bus.startOfFrame) begin
        if (playerHit && cnt == '0) begin
          hit <= 1'b1;
          cnt <= CNT_W'(INVULN_FRAMES);
        end else if (cnt != '0) cnt <= cnt - 1'b1;
        if (stage == S_HUGE && flags[1]) begin
          stage <= S_BIG;
          hugeEn <= 1'b0;
          big1 <= 1'b1;
          big2 <= 1'b1;
          spawn <= 1'b1;
          ropeRst <= 1'b1;
        end
        if (stage == S_BIG) begin
          big1 <= big1 & ~ret1;
          big2 <= big2 & ~ret2;
          ropeRst <= ret1 | ret2;
          if (!(big1 & ~ret1) && !(big2 & ~ret2)) begin
            stage <= S_CLEARED;
            cleared <= 1'b1;
          end
        end
      end
    end
  end
  assign bus.spawnX = spawnX;
  assign bus.hugeBall_en = hugeEn;
  assign bus.bigBall1_en = big1;
  assign bus.bigBall2_en = big2;
  assign bus.bigBall_spawn = spawn;
  assign bus.rope_reset = ropeRst;
  assign bus.player_hit = hit;
  assign bus.player_invuln = cnt != '0;
  assign bus.level_cleared = cleared;
endmodule

// File: tb/tb_hugeball_split_controller.sv
// tb_hugeball_split_controller: directed and random checks of the split controller against a frame-level model
module tb_hugeball_split_controller;
  localparam int INV = 3;
  localparam bit [5:0] PH = 6'd1, RH = 6'd2, PB1 = 6'd4, RB1 = 6'd8, RB2 = 6'd32;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;
  hugeball_split_controller_if #(.X_W(11)) bus();
  hugeball_split_controller #(.INVULN_FRAMES(INV), .CNT_W(6), .X_W(11)) dut (
    .clk(clk),
    .resetN(resetN),
    .bus(bus)
  );
  int nAssert = 0;
  int nFail = 0;
  bit mHuge, mB1, mB2, mClr, mSpawn, mRope, mHit;
  int mCnt;
  logic [10:0] mX;
  bit [5:0] pend;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nAssert++;
    assert (got === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  // frame-level reference: hits gathered over a frame are judged all at once on the frame edge
  task automatic model(input bit sof, input bit sl, input bit [5:0] col, input logic [10:0] x, input bit rn);
    bit ph, r1, r2;
    mSpawn = 0;
    mRope = 0;
    mHit = 0;
    if (!rn) begin
      mHuge = 1; mB1 = 0; mB2 = 0; mClr = 0; mCnt = 0; mX = 0; pend = 0;
    end else if (sl) begin
      mHuge = 1; mB1 = 0; mB2 = 0; mClr = 0; mCnt = 0; pend = 0;
    end else begin
      if (col[1] && !pend[1]) mX = x;
      if (sof) begin
        ph = !mClr && ((pend[0] && mHuge) || (pend[2] && mB1) || (pend[4] && mB2));
        if (ph && mCnt == 0) begin
          mHit = 1;
          mCnt = INV;
        end else if (mCnt > 0) mCnt--;
        if (mHuge) begin
          if (pend[1]) begin
            mHuge = 0; mB1 = 1; mB2 = 1; mSpawn = 1; mRope = 1;
          end
        end else if (!mClr) begin
          r1 = pend[3] && mB1;
          r2 = pend[5] && mB2;
          mB1 = mB1 && !r1;
          mB2 = mB2 && !r2;
          mRope = r1 || r2;
          mClr = !mB1 && !mB2;
        end
        pend = col;
      end else pend |= col;
    end
  endtask
  task automatic cyc(input bit sof, input bit sl, input bit [5:0] col, input logic [10:0] x, input bit rn);
    bus.startOfFrame = sof;
    bus.startLevel = sl;
    {bus.col_rope_bigBall2, bus.col_player_bigBall2, bus.col_rope_bigBall1,
     bus.col_player_bigBall1, bus.col_rope_hugeBall, bus.col_player_hugeBall} = col;
    bus.hugeBallX = x;
    resetN = rn;
    @(posedge clk);
    model(sof, sl, col, x, rn);
    #1;
    chk("hugeBall_en", bus.hugeBall_en, mHuge);
    chk("bigBall1_en", bus.bigBall1_en, mB1);
    chk("bigBall2_en", bus.bigBall2_en, mB2);
    chk("spawnX", bus.spawnX, mX);
    chk("bigBall_spawn", bus.bigBall_spawn, mSpawn);
    chk("rope_reset", bus.rope_reset, mRope);
    chk("player_hit", bus.player_hit, mHit);
    chk("player_invuln", bus.player_invuln, mCnt != 0);
    chk("level_cleared", bus.level_cleared, mClr);
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 1);
  endtask
  task automatic frameEdge();
    cyc(1, 0, 0, 0, 1);
  endtask
  initial begin
    bit [5:0] c;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("reset_hugeEn", bus.hugeBall_en, 1);
    chk("reset_cleared", bus.level_cleared, 0);
    idle(3);
    cyc(0, 0, PH, 0, 1); idle(2); frameEdge();
    chk("inv_hit1", bus.player_hit, 1);
    cyc(0, 0, PH, 0, 1); idle(2); frameEdge();
    chk("inv_hit2_ignored", bus.player_hit, 0);
    chk("inv_high_f2", bus.player_invuln, 1);
    idle(2); frameEdge();
    chk("inv_high_f3", bus.player_invuln, 1);
    idle(2); frameEdge();
    chk("inv_low_f4", bus.player_invuln, 0);
    cyc(0, 0, PH, 0, 1); idle(2); frameEdge();
    chk("inv_hit_f5", bus.player_hit, 1);
    idle(3);
    cyc(0, 0, RH, 200, 1); cyc(0, 0, RH, 215, 1); idle(1); cyc(0, 0, RH, 230, 1); idle(2); frameEdge();
    chk("split_spawnX", bus.spawnX, 200);
    chk("split_spawn", bus.bigBall_spawn, 1);
    chk("split_rope", bus.rope_reset, 1);
    chk("split_hugeEn", bus.hugeBall_en, 0);
    chk("split_big", {bus.bigBall1_en, bus.bigBall2_en}, 2'b11);
    idle(1);
    chk("split_pulse_end", bus.bigBall_spawn, 0);
    frameEdge(); frameEdge(); frameEdge();
    cyc(0, 0, RB1, 0, 1); idle(2); frameEdge();
    chk("retire1_rope", bus.rope_reset, 1);
    chk("retire1_en", bus.bigBall1_en, 0);
    cyc(0, 0, RB1 | PB1, 0, 1); idle(2); frameEdge();
    chk("dead_rope", bus.rope_reset, 0);
    chk("dead_hit", bus.player_hit, 0);
    chk("dead_big2", bus.bigBall2_en, 1);
    cyc(0, 1, 0, 0, 1);
    chk("restart_hugeEn", bus.hugeBall_en, 1);
    cyc(0, 0, RH, 400, 1); frameEdge();
    cyc(0, 0, RB1 | RB2, 0, 1); idle(2); frameEdge();
    chk("dbl_rope", bus.rope_reset, 1);
    chk("dbl_cleared", bus.level_cleared, 1);
    chk("dbl_big", {bus.bigBall1_en, bus.bigBall2_en}, 2'b00);
    idle(1);
    chk("dbl_single_pulse", bus.rope_reset, 0);
    cyc(0, 1, 0, 0, 1);
    chk("lvl_hugeEn", bus.hugeBall_en, 1);
    chk("lvl_cleared", bus.level_cleared, 0);
    idle(2);
    cyc(1, 0, RH, 77, 1);
    chk("bnd_no_split", bus.bigBall_spawn, 0);
    chk("bnd_spawnX", bus.spawnX, 77);
    idle(3); frameEdge();
    chk("bnd_split", bus.bigBall_spawn, 1);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, RH | PH, 50, 1);
    cyc(0, 0, 0, 0, 0);
    frameEdge();
    chk("rst_no_spawn", bus.bigBall_spawn, 0);
    chk("rst_no_hit", bus.player_hit, 0);
    chk("rst_hugeEn", bus.hugeBall_en, 1);
    cyc(1, 1, RH, 9, 1);
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 6; b++) c[b] = $urandom_range(0, 29) == 0;
      cyc((i % 12) == 11 || $urandom_range(0, 40) == 0, $urandom_range(0, 250) == 0, c,
          11'($urandom_range(0, 2047)), $urandom_range(0, 700) != 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule

// File: doc/hugeball_split_controller.md
# hugeball_split_controller

Per-level ball-lifecycle sequencer for the huge-ball stage of the game. It accumulates the pixel-rate collision strobes from the collision detector over each video frame and acts on them once per frame at `startOfFrame`. At that point it splits the huge ball into two big balls, retires big balls hit by the rope, reports player hits with a post-hit invulnerability window, and flags level completion. It sits between the collision detector and the ball, rope and player drawing/motion blocks.

## Interface
Parameters:
- `INVULN_FRAMES`, 60: number of frames player collisions are ignored after a reported hit.
- `CNT_W`, 6: invulnerability counter width. Must satisfy `INVULN_FRAMES < 2**CNT_W`.
- `X_W`, 11: pixel X coordinate width.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - `clk`  in  1  system/pixel clock.
  - `resetN`  in  1  synchronous active-low reset.
- Frame and level control:
  - `startOfFrame`  in  1  one-cycle pulse per frame.
  - `startLevel`  in  1  one-cycle pulse: restart level from the huge-ball stage.
- Collision strobes (pixel rate, from the collision detector):
  - `col_player_hugeBall`, `col_rope_hugeBall`  in  1 each.
  - `col_player_bigBall1`, `col_rope_bigBall1`  in  1 each.
  - `col_player_bigBall2`, `col_rope_bigBall2`  in  1 each.
- Position and enables:
  - `hugeBallX`  in  X_W  current huge-ball X position.
  - `hugeBall_en`  out  1  huge ball alive/drawn.
  - `bigBall1_en`, `bigBall2_en`  out  1 each  big ball alive/drawn.
- Action pulses and status:
  - `spawnX`  out  X_W  big-ball spawn X, held until next capture.
  - `bigBall_spawn`  out  1  one-cycle pulse: big balls load `spawnX`.
  - `rope_reset`  out  1  one-cycle pulse: retract rope.
  - `player_hit`  out  1  one-cycle pulse: lose a life.
  - `player_invuln`  out  1  high while the invulnerability counter is nonzero.
  - `level_cleared`  out  1  level-high once all balls are destroyed.

## Operation
- FSM states: `S_HUGE`, `S_BIG`, `S_CLEARED`.
- Reset state is `S_HUGE`. Reset values: `hugeBall_en=1`; all other outputs 0; counter 0; all sticky flags 0.
- Collision latching:
  - Each collision input ORs into its own sticky flag on every edge.
  - On a `startOfFrame` edge, evaluation uses the flag values from before that edge.
  - On that same edge, the flags are reloaded with the current inputs only, so a strobe coincident with `startOfFrame` counts toward the next frame.
- `spawnX` capture: taken from `hugeBallX` on the first edge in a frame where `col_rope_hugeBall`=1 and its flag is 0. Later hits in the same frame do not overwrite it.
- Evaluation in `S_HUGE`, on rope-huge flag:
  - `hugeBall_en`→0 and both big-ball alive bits→1.
  - Pulse `bigBall_spawn` and `rope_reset`.
  - Next state `S_BIG`.
- Evaluation in `S_BIG`:
  - A rope-bigN flag clears alive bit N only if ball N is alive. Flags for dead balls are ignored.
  - One `rope_reset` pulse is issued if at least one ball is retired; two balls retired in the same frame still give a single pulse.
  - When both alive bits become 0, next state is `S_CLEARED`.
- `S_CLEARED`: `level_cleared`=1 and all ball enables are 0. The FSM waits for `startLevel`.
- Player hits (any state except `S_CLEARED`):
  - Only player flags of currently alive balls count.
  - If the counter is 0: pulse `player_hit` and load the counter with `INVULN_FRAMES`.
  - Otherwise the hit is ignored.
- Counter: decrements by 1 on each `startOfFrame` edge where it is nonzero and no new load happens. It saturates at 0.
- A frame containing both a rope hit and a player hit on the huge ball performs both the split and the player-hit action.
- `startLevel`, accepted in any state and at any cycle:
  - Next edge: `S_HUGE`, flags cleared, counter cleared, all pulses 0.
  - It has priority over a coincident `startOfFrame` evaluation.
- `resetN`=0 mid-frame restores the reset state on that edge. Pending flags are discarded.

## Timing
- Outputs are fully registered. Pulses are high for exactly the one cycle following the `startOfFrame` edge.
- State and enable changes are visible in that same following cycle.
- `spawnX` becomes valid the cycle after its capture edge, and never later than `bigBall_spawn`.
- `player_invuln` follows the counter with no extra delay.
- There is no combinational path from inputs to outputs.

## Structure
- Shared package `bubble_pkg` holds:
  - the state typedef `ball_stage_t` (`S_HUGE`, `S_BIG`, `S_CLEARED`);
  - `X_W`;
  - the default `INVULN_FRAMES`.
- Sub-module `collision_frame_latch`: N-bit sticky flags with snapshot-and-reload on `startOfFrame` and a clear input. Instantiated once with N=6.

## Test plan
- Split: rope-huge strobe on 3 cycles mid-frame with `hugeBallX`=200, 215, 230, then `startOfFrame` → next cycle: `bigBall_spawn`=1, `rope_reset`=1, `spawnX`=200, `hugeBall_en`=0, both big enables 1.
- Boundary: rope-huge strobe only on the `startOfFrame` cycle → no action that frame; split at the following `startOfFrame`.
- Double retire: rope hits bigBall1 and bigBall2 in the same frame → a single `rope_reset` pulse, both enables 0, `level_cleared`=1; then `startLevel` → `hugeBall_en`=1, `level_cleared`=0.
- Invulnerability (`INVULN_FRAMES`=3):
  - Player-huge hits in frames 1 and 2 → one `player_hit` pulse, after frame 1.
  - `player_invuln` stays high for 3 frame boundaries.
  - A hit in frame 5 → second `player_hit` pulse.
- Dead-ball gating: after bigBall1 is retired, strobes on `col_rope_bigBall1` and `col_player_bigBall1` → no pulses, state unchanged.
- Reset mid-frame: flags pending, `resetN`=0 for one cycle, then `startOfFrame` → no pulses, `hugeBall_en`=1.
